// File: rtl/present_pkg.sv
// PRESENT-80 shared constants, state encoding and cipher/key-schedule helpers.
package present_pkg;

  localparam int BLOCK_W    = 64;
  localparam int KEY_W      = 80;
  localparam int NUM_ROUNDS = 31;

  typedef logic [3:0] sbox_t [16];

  localparam sbox_t SBOX = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = sbox4(s[4*i +: 4]);
    return r;
  endfunction

  // bit i lands on 16*i mod 63; the top bit is a fixed point
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++)
      r[(16*i) % 63] = s[i];
    r[63] = s[63];
    return r;
  endfunction

  function automatic logic [79:0] key_update(
    input logic [79:0] k,
    input logic [4:0]  rc
  );
    logic [79:0] n;
    n          = {k[18:0], k[79:19]};
    n[79:76]   = sbox4(n[79:76]);
    n[19:15]   = n[19:15] ^ rc;
    return n;
  endfunction

endpackage

// File: rtl/present_round_round.sv
// One PRESENT round: key add, S-box layer and bit permutation.
module present_round
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] rk,
  output logic [BLOCK_W-1:0] nxt
);

  assign nxt = p_layer(sbox_layer(state ^ rk));

endmodule

// File: rtl/present_round_ctrl.sv
// Iterative PRESENT-80 engine: one round per clock, round keys derived on the fly.
module present_round_ctrl
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               busy,
  output logic [4:0]         round_cnt
);

  localparam logic [4:0] LAST_RND = 5'(NUM_ROUNDS);

  state_e               state_q, state_d;
  logic [BLOCK_W-1:0]   blk_q;
  logic [KEY_W-1:0]     key_q;
  logic [4:0]           cnt_q;
  logic [BLOCK_W-1:0]   out_q;
  logic [BLOCK_W-1:0]   rnd_out;
  logic [KEY_W-1:0]     key_nxt;
  logic                 last;

  present_round u_round (
    .state (blk_q),
    .rk    (key_q[79:16]),
    .nxt   (rnd_out)
  );

  assign key_nxt = key_update(key_q, cnt_q);
  assign last    = (cnt_q == LAST_RND);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blk_q <= '0;
      key_q <= '0;
      cnt_q <= '0;
      out_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          blk_q <= in_data;
          key_q <= in_key;
          cnt_q <= 5'd1;
        end
        RUN: begin
          blk_q <= rnd_out;
          key_q <= key_nxt;
          if (last) begin
            // final whitening uses K32, the key after the 31st update
            out_q <= rnd_out ^ key_nxt[79:16];
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        DONE: if (out_ready) cnt_q <= '0;
        default: cnt_q <= '0;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_q;
  assign round_cnt = cnt_q;

endmodule

// File: tb/tb_present_round_ctrl.sv
// Self-checking bench for present_round_ctrl: known answers, random jobs, corner sequences.
module tb_present_round_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [79:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  logic [4:0]  round_cnt;

  int total;
  int bad;

  typedef struct {
    logic [63:0] pt;
    logic [79:0] key;
    logic [63:0] ct;
  } kat_t;

  kat_t kat [4];
  int   sbt [16];

  present_round_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_cnt (round_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference cipher, straight from the algorithm description
  function automatic logic [63:0] ref_enc(input logic [63:0] pt,
                                          input logic [79:0] key);
    logic [63:0] s, t, u;
    logic [79:0] k;
    int dst;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++)
        t[4*n +: 4] = 4'(sbt[int'(s[4*n +: 4])]);
      for (int b = 0; b < 64; b++) begin
        dst = (b == 63) ? 63 : (b * 16) % 63;
        u[dst] = t[b];
      end
      s = u;
      k = (k << 61) | (k >> 19);
      k[79:76] = 4'(sbt[int'(k[79:76])]);
      k[19:15] = k[19:15] ^ 5'(r);
    end
    return s ^ k[79:16];
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [63:0] pt, input logic [79:0] key,
                         input logic [63:0] exp, input string nm,
                         input bit rel);
    int n;
    int errs;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    in_valid = 1'b1;
    in_data  = pt;
    in_key   = key;
    step();
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom()};
    in_key   = {16'($urandom()), $urandom(), $urandom()};
    n = 0;
    errs = 0;
    while (!out_valid && n < 40) begin
      if (round_cnt != 5'(n + 1) || !busy || in_ready) errs++;
      step();
      n++;
    end
    check({nm, " latency"}, 80'(n), 80'd31);
    check({nm, " cnt/busy"}, 80'(errs), 80'd0);
    check({nm, " data"}, {16'h0, out_data}, {16'h0, exp});
    check({nm, " done st"}, {busy, in_ready, round_cnt}, {1'b1, 1'b0, 5'd0});
    if (rel) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({nm, " release"}, {out_valid, in_ready, busy}, 3'b010);
    end
  endtask

  initial begin
    int n;
    int errs;
    int idx;
    int outs;
    int cyc;
    int extra;
    int acc_cyc [4];
    logic pre_rdy;
    logic [63:0] pt;
    logic [79:0] key;

    total = 0;
    bad   = 0;
    sbt = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    kat[0] = '{64'h0, 80'h0, 64'h5579C1387B228445};
    kat[1] = '{64'h0, {80{1'b1}}, 64'hE72C46C0F5945049};
    kat[2] = '{{64{1'b1}}, 80'h0, 64'hA112FFC72F68417B};
    kat[3] = '{{64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2};

    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_key    = '0;
    out_ready = 1'b0;
    #3;
    check("reset outs", {in_ready, out_valid, busy, round_cnt},
          {1'b1, 1'b0, 1'b0, 5'd0});
    check("reset data", {16'h0, out_data}, 80'h0);
    #9 reset = 1'b1;
    step();

    for (int i = 0; i < 4; i++)
      run_job(kat[i].pt, kat[i].key, kat[i].ct, $sformatf("kat%0d", i), 1'b1);

    for (int i = 0; i < 6; i++) begin
      pt  = {$urandom(), $urandom()};
      key = {16'($urandom()), $urandom(), $urandom()};
      run_job(pt, key, ref_enc(pt, key), $sformatf("rnd%0d", i), 1'b1);
    end

    // backpressure in DONE with noisy input side
    run_job(kat[0].pt, kat[0].key, kat[0].ct, "bp", 1'b0);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom(), $urandom()};
      step();
      if (out_data !== kat[0].ct || in_ready || !out_valid) errs++;
    end
    check("bp hold", 80'(errs), 80'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp release", {in_ready, out_valid, busy, round_cnt},
          {1'b1, 1'b0, 1'b0, 5'd0});

    // asynchronous reset in the middle of a job
    in_valid = 1'b1;
    in_data  = kat[3].pt;
    in_key   = kat[3].key;
    step();
    in_valid = 1'b0;
    n = 0;
    while (round_cnt != 5'd15 && n < 40) begin
      step();
      n++;
    end
    check("mid reach", 80'(n), 80'd14);
    #2 reset = 1'b0;
    #1;
    check("mid reset", {in_ready, out_valid, busy, round_cnt},
          {1'b1, 1'b0, 1'b0, 5'd0});
    check("mid data", {16'h0, out_data}, 80'h0);
    #2 reset = 1'b1;
    step();
    run_job(kat[1].pt, kat[1].key, kat[1].ct, "post rst", 1'b1);

    // back-to-back jobs with in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = kat[0].pt;
    in_key    = kat[0].key;
    idx  = 0;
    outs = 0;
    cyc  = 0;
    while (outs < 4 && cyc < 300) begin
      pre_rdy = in_ready;
      step();
      cyc++;
      if (pre_rdy && in_valid) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) begin
          in_data = kat[idx].pt;
          in_key  = kat[idx].key;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        check($sformatf("b2b out%0d", outs), {16'h0, out_data},
              {16'h0, kat[outs].ct});
        outs++;
      end
    end
    check("b2b outs", 80'(outs), 80'd4);
    check("b2b accepts", 80'(idx), 80'd4);
    for (int i = 1; i < 4; i++)
      check($sformatf("b2b gap%0d", i), 80'(acc_cyc[i] - acc_cyc[i-1]), 80'd33);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid || busy) extra++;
    end
    check("b2b no dup", 80'(extra), 80'd0);
    out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
